// File: rtl/aes_core_scheduler_pkg.sv
// Shared definitions for the AES core scheduler: FSM encoding and the core's
// operation_mode / aes_mode constants.
package aes_core_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ABORT
    } sched_state_e;

    // Same encodings the AES core decodes on operation_mode / aes_mode
    localparam logic [1:0] ENCRYPTION     = 2'b00;
    localparam logic [1:0] KEY_DERIVATION = 2'b01;
    localparam logic [1:0] DECRYPTION     = 2'b10;
    localparam logic [1:0] DECRYP_W_DERIV = 2'b11;

    localparam logic [1:0] ECB = 2'b00;
    localparam logic [1:0] CBC = 2'b01;
    localparam logic [1:0] CTR = 2'b10;

endpackage

// File: rtl/aes_core_scheduler_if.sv
// Requester and AES-core control signals of the scheduler, bundled as one bus.
// master = requesters + core side (drives req / end_comp), slave = scheduler.
interface aes_core_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] req_op_mode;
    logic [2*NUM_REQ-1:0] req_aes_mode;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic                 core_start;
    logic [1:0]           core_op_mode;
    logic [1:0]           core_aes_mode;
    logic                 core_disable;
    logic                 core_end_comp;
    logic                 busy;
    logic [ID_W-1:0]      owner;

    modport master (
        output req, req_op_mode, req_aes_mode, core_end_comp,
        input  gnt, done, err, core_start, core_op_mode, core_aes_mode,
               core_disable, busy, owner
    );

    modport slave (
        input  req, req_op_mode, req_aes_mode, core_end_comp,
        output gnt, done, err, core_start, core_op_mode, core_aes_mode,
               core_disable, busy, owner
    );
endinterface

// File: rtl/aes_core_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Returns one-hot grant and its index.
module aes_core_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               vld,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    int cand;

    always_comb begin
        vld  = 1'b0;
        gnt  = '0;
        idx  = '0;
        cand = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one AES core between NUM_REQ requesters: round-robin grant, start
// pulse with latched modes, watchdog/abort handling and done/err pulses.
module aes_core_scheduler
    import aes_core_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ID_W        = 1,   // must equal clog2(NUM_REQ)
    parameter int TIMEOUT_CYC = 128
) (
    input logic                clk,
    input logic                rst_n,
    aes_core_scheduler_if.slave bus
);

    localparam logic [7:0]      WD_LAST  = 8'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);

    sched_state_e        state, state_nxt;
    logic [ID_W-1:0]     own_q, rr_ptr;
    logic [NUM_REQ-1:0]  gnt_q, own_oh;
    logic [1:0]          op_q, aes_q;
    logic                start_q;
    logic [7:0]          wd_cnt;

    logic                arb_vld;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_idx;

    aes_core_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req (bus.req),
        .ptr (rr_ptr),
        .vld (arb_vld),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Completion has priority over both watchdog expiry and owner abort
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arb_vld) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_RUN;
            S_RUN: begin
                if (bus.core_end_comp)
                    state_nxt = S_DONE;
                else if (wd_cnt == WD_LAST || !bus.req[own_q])
                    state_nxt = S_ABORT;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q   <= '0;
            rr_ptr  <= '0;
            gnt_q   <= '0;
            op_q    <= ENCRYPTION;
            aes_q   <= ECB;
            start_q <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            // Start fires the cycle after LOAD so the modes are already stable
            start_q <= (state == S_LOAD);
            case (state)
                S_IDLE: if (arb_vld) begin
                    own_q <= arb_idx;
                    gnt_q <= arb_gnt;
                    op_q  <= bus.req_op_mode[2*int'(arb_idx) +: 2];
                    aes_q <= bus.req_aes_mode[2*int'(arb_idx) +: 2];
                end
                S_LOAD: wd_cnt <= '0;
                S_RUN: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    if (state_nxt != S_RUN) gnt_q <= '0;
                end
                S_DONE, S_ABORT: begin
                    rr_ptr <= (own_q == LAST_ID) ? '0 : own_q + 1'b1;
                    own_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    // The IDLE cycle between ABORT and the next LOAD gives the core time to settle
    assign own_oh            = NUM_REQ'(1) << own_q;
    assign bus.gnt           = gnt_q;
    assign bus.done          = (state == S_DONE)  ? own_oh : '0;
    assign bus.err           = (state == S_ABORT) ? own_oh : '0;
    assign bus.core_disable  = (state == S_ABORT);
    assign bus.core_start    = start_q;
    assign bus.core_op_mode  = op_q;
    assign bus.core_aes_mode = aes_q;
    assign bus.busy          = (state != S_IDLE);
    assign bus.owner         = own_q;

endmodule
